// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between requesters A and B.
// Optional macro UART_TX_ARB_TIMEOUT_EN abandons transfers whose done edge never arrives.
module uart_tx_arbiter #(
    parameter int unsigned WIDTH_WORD     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req_a,
    input  logic [WIDTH_WORD-1:0] i_data_a,
    output logic                  o_ack_a,
    input  logic                  i_req_b,
    input  logic [WIDTH_WORD-1:0] i_data_b,
    output logic                  o_ack_b,
    output logic                  o_tx_start,
    output logic [WIDTH_WORD-1:0] o_data_tx,
    input  logic                  i_tx_done,
    output logic [1:0]            o_grant,
    output logic                  o_busy,
    output logic                  o_timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Elaboration-time guard on the supported timeout range
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    state_t                state_q, state_d;
    logic                  prio_b_q, prio_b_d;
    logic                  done_q;
    logic                  done_rise;
    logic                  grant_a, grant_b;
    logic                  ack_a_d, ack_b_d, tx_start_d, busy_d;
    logic [1:0]            grant_d;
    logic [WIDTH_WORD-1:0] data_tx_d;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_d;
`endif

    // prio_b_q set means B wins a tie (A was served last)
    assign grant_a   = i_req_a && (!i_req_b || !prio_b_q);
    assign grant_b   = i_req_b && !grant_a;
    assign done_rise = i_tx_done && !done_q;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        prio_b_d   = prio_b_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        tx_start_d = 1'b0;
        data_tx_d  = o_data_tx;
        grant_d    = o_grant;
        busy_d     = o_busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    state_d    = START;
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    ack_a_d    = grant_a;
                    ack_b_d    = grant_b;
                    grant_d    = {grant_b, grant_a};
                    data_tx_d  = grant_a ? i_data_a : i_data_b;
                    prio_b_d   = grant_a;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done edge wins over a simultaneous timeout
                if (done_rise) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    busy_d  = 1'b0;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    grant_d   = 2'b00;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            prio_b_q   <= 1'b0;
            done_q     <= 1'b0;
            o_ack_a    <= 1'b0;
            o_ack_b    <= 1'b0;
            o_tx_start <= 1'b0;
            o_data_tx  <= '0;
            o_grant    <= 2'b00;
            o_busy     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_b_q   <= prio_b_d;
            done_q     <= i_tx_done;
            o_ack_a    <= ack_a_d;
            o_ack_b    <= ack_b_d;
            o_tx_start <= tx_start_d;
            o_data_tx  <= data_tx_d;
            o_grant    <= grant_d;
            o_busy     <= busy_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q     <= '0;
            o_timeout <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            o_timeout <= timeout_d;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle vector table plus hand-written corner sequences.
module tb_uart_tx_arbiter;

    localparam int unsigned W          = 8;
    localparam int unsigned TB_TIMEOUT = 40;
    localparam int unsigned NVEC       = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_a, req_b, tx_done;
    logic [W-1:0] data_a, data_b;
    logic         ack_a, ack_b, tx_start, busy, timeout;
    logic [W-1:0] data_tx;
    logic [1:0]   grant;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         req_a;
        logic [W-1:0] data_a;
        logic         req_b;
        logic [W-1:0] data_b;
        logic         done;
        logic         ack_a;
        logic         ack_b;
        logic         start;
        logic [1:0]   grant;
        logic         busy;
        logic [W-1:0] data;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .WIDTH_WORD     (W),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_req_a    (req_a),
        .i_data_a   (data_a),
        .o_ack_a    (ack_a),
        .i_req_b    (req_b),
        .i_data_b   (data_b),
        .o_ack_b    (ack_b),
        .o_tx_start (tx_start),
        .o_data_tx  (data_tx),
        .i_tx_done  (tx_done),
        .o_grant    (grant),
        .o_busy     (busy),
        .o_timeout  (timeout)
    );

    // Observed outputs packed as {ack_a, ack_b, start, grant, busy, timeout, data}
    function automatic logic [14:0] outs();
        return {ack_a, ack_b, tx_start, grant, busy, timeout, data_tx};
    endfunction

    function automatic logic [14:0] mk_exp(input logic a, input logic b, input logic s,
                                           input logic [1:0] g, input logic bz,
                                           input logic [W-1:0] d);
        return {a, b, s, g, bz, 1'b0, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int starts, acks, drops, tout_at;

        // Round-robin table: both requesters held, A served first after reset
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 8'h11};
        vecs[1]  = '{1'b0, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'h11};
        vecs[2]  = '{1'b0, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'h11};
        vecs[3]  = '{1'b0, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h11};
        vecs[4]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 8'h22};
        vecs[5]  = '{1'b1, 8'h11, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 8'h22};
        vecs[6]  = '{1'b1, 8'h11, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 8'h22};
        vecs[7]  = '{1'b1, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 8'h22};
        vecs[8]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h22};
        vecs[9]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 8'h11};
        vecs[10] = '{1'b0, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'h11};
        vecs[11] = '{1'b0, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h11};
        vecs[12] = '{1'b0, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 8'h22};
        vecs[13] = '{1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 8'h22};

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; tx_done = 1'b0;
        data_a = '0; data_b = '0;
        #1;
        check("reset_outputs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < int'(NVEC); i++) begin
            req_a = vecs[i].req_a; data_a = vecs[i].data_a;
            req_b = vecs[i].req_b; data_b = vecs[i].data_b;
            tx_done = vecs[i].done;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'(mk_exp(vecs[i].ack_a, vecs[i].ack_b, vecs[i].start,
                             vecs[i].grant, vecs[i].busy, vecs[i].data)));
        end
        tx_done = 1'b1; tick();
        tx_done = 1'b0; tick();

        // Single A request, done edge about 20 cycles after start
        req_a = 1'b1; data_a = 8'hA5;
        tick();
        check("single_a_grant", 32'(outs()), 32'(mk_exp(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 8'hA5)));
        req_a = 1'b0;
        starts = 0; acks = 0; drops = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            starts += int'(tx_start);
            acks   += int'(ack_a | ack_b);
            drops  += int'(!busy);
        end
        check("single_a_wait", 32'({8'(starts), 8'(acks), 8'(drops)}), 32'd0);
        tx_done = 1'b1;
        tick();
        check("single_a_release", 32'(outs()), 32'(mk_exp(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'hA5)));

        // Request from B arriving during WAIT_DONE waits for IDLE
        req_a = 1'b1; data_a = 8'h5A;
        tick();
        check("late_b_a_grant", 32'(outs()), 32'(mk_exp(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 8'h5A)));
        req_a = 1'b0;
        tick();
        req_b = 1'b1; data_b = 8'h22;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            acks += int'(ack_b) + int'(!busy);
        end
        check("late_b_no_ack", 32'(acks), 32'd0);
        tx_done = 1'b0; tick();
        tx_done = 1'b1; tick();
        check("late_b_release", 32'(outs()), 32'(mk_exp(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h5A)));
        tick();
        check("late_b_grant", 32'(outs()), 32'(mk_exp(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 8'h22)));

        // Done held high across release and the next START must not end it
        req_b = 1'b0;
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            drops += int'(!busy);
        end
        check("held_done_ignored", 32'(drops), 32'd0);
        tx_done = 1'b0; tick();
        tx_done = 1'b1; tick();
        check("fresh_edge_release", 32'(outs()), 32'(mk_exp(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h22)));

        // Reset in WAIT_DONE, then B alone is granted on the first edge
        tx_done = 1'b0;
        req_a = 1'b1; data_a = 8'h3C;
        tick();
        req_a = 1'b0;
        tick(); tick();
        check("pre_reset_busy", 32'({grant, busy}), 32'({2'b01, 1'b1}));
        rst = 1'b1;
        #1;
        check("async_reset", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0; req_b = 1'b1; data_b = 8'h22;
        tick();
        check("post_reset_b", 32'(outs()), 32'(mk_exp(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 8'h22)));
        req_b = 1'b0;

`ifdef UART_TX_ARB_TIMEOUT_EN
        tout_at = 0;
        for (int i = 1; i <= int'(TB_TIMEOUT) + 5; i++) begin
            tick();
            if (timeout && tout_at == 0) begin
                tout_at = i;
                check("timeout_busy_low", 32'({grant, busy}), 32'd0);
            end
        end
        check("timeout_cycle", 32'(tout_at), 32'(TB_TIMEOUT + 1));
`else
        tout_at = 0; drops = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            tout_at += int'(timeout);
            drops   += int'(!busy);
        end
        check("no_timeout_busy_held", 32'({16'(tout_at), 16'(drops)}), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
